// File: rtl/bypass_wb_sequencer.sv
// Writeback/free sequencer in front of the bypassing register file: buffers out-of-order
// completions, issues up to two RF writes per cycle oldest-first, and frees names in allocation order.
module bypass_wb_sequencer #(
    parameter int data_width = 32,
    parameter int name_width = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ALLOC_FIRE,
    input  logic [name_width-1:0] ALLOC_NAME,
    input  logic                  CMP_VALID_1,
    input  logic [name_width-1:0] CMP_NAME_1,
    input  logic [data_width-1:0] CMP_DATA_1,
    output logic                  CMP_READY_1,
    input  logic                  CMP_VALID_2,
    input  logic [name_width-1:0] CMP_NAME_2,
    input  logic [data_width-1:0] CMP_DATA_2,
    output logic                  CMP_READY_2,
    input  logic                  REL_E_1,
    input  logic [name_width-1:0] REL_NAME_1,
    input  logic                  REL_E_2,
    input  logic [name_width-1:0] REL_NAME_2,
    output logic                  WE_1,
    output logic [name_width-1:0] NAME_IN_1,
    output logic [data_width-1:0] D_IN_1,
    output logic                  WE_2,
    output logic [name_width-1:0] NAME_IN_2,
    output logic [data_width-1:0] D_IN_2,
    output logic                  WFE,
    output logic [name_width-1:0] W_F,
    input  logic                  F_READY,
    output logic                  ERR
);
    localparam int num_names = 2 ** name_width;

    // state    | meaning
    // S_EMPTY  | name not allocated
    // S_ALLOC  | allocated, awaiting completion
    // S_PEND   | result buffered, awaiting RF write
    // S_WRIT   | written to RF, freeable once released
    typedef enum logic [1:0] {S_EMPTY, S_ALLOC, S_PEND, S_WRIT} name_st_e;

    name_st_e              st_q   [num_names];
    name_st_e              st_d   [num_names];
    logic [data_width-1:0] data_q [num_names];
    logic [data_width-1:0] data_d [num_names];
    logic [num_names-1:0]  rel_q, rel_d;
    logic [name_width-1:0] fptr_q, fptr_d;
    logic                  err_q, err_d;

    logic                  we1, we2;
    logic [name_width-1:0] n1, n2, idx;
    logic                  rdy1, rdy2, wfe, do_free;

    // Oldest-first scan starting at the free pointer picks the two writes.
    always_comb begin
        we1 = 1'b0;
        we2 = 1'b0;
        n1  = '0;
        n2  = '0;
        idx = '0;
        for (int i = 0; i < num_names; i++) begin
            idx = fptr_q + name_width'(i);
            if (st_q[idx] == S_PEND) begin
                if (!we1) begin
                    we1 = 1'b1;
                    n1  = idx;
                end else if (!we2) begin
                    we2 = 1'b1;
                    n2  = idx;
                end
            end
        end
    end

    assign rdy1    = (st_q[CMP_NAME_1] == S_ALLOC);
    assign rdy2    = (st_q[CMP_NAME_2] == S_ALLOC) && !(CMP_VALID_1 && (CMP_NAME_1 == CMP_NAME_2));
    assign wfe     = (st_q[fptr_q] == S_WRIT) && rel_q[fptr_q];
    assign do_free = wfe && F_READY;

    always_comb begin
        st_d   = st_q;
        data_d = data_q;
        rel_d  = rel_q;
        fptr_d = fptr_q;
        err_d  = err_q;

        if (we1) st_d[n1] = S_WRIT;
        if (we2) st_d[n2] = S_WRIT;

        if (CMP_VALID_1 && rdy1) begin
            st_d[CMP_NAME_1]   = S_PEND;
            data_d[CMP_NAME_1] = CMP_DATA_1;
        end
        if (CMP_VALID_2 && rdy2) begin
            st_d[CMP_NAME_2]   = S_PEND;
            data_d[CMP_NAME_2] = CMP_DATA_2;
        end

        if (REL_E_1) begin
            if (st_q[REL_NAME_1] != S_EMPTY) rel_d[REL_NAME_1] = 1'b1;
            else                             err_d = 1'b1;
        end
        if (REL_E_2) begin
            if (st_q[REL_NAME_2] != S_EMPTY) rel_d[REL_NAME_2] = 1'b1;
            else                             err_d = 1'b1;
        end

        // A name being freed this cycle is still WRIT, so allocating it flags an error.
        if (ALLOC_FIRE) begin
            if (st_q[ALLOC_NAME] == S_EMPTY) st_d[ALLOC_NAME] = S_ALLOC;
            else                             err_d = 1'b1;
        end

        if (do_free) begin
            st_d[fptr_q]  = S_EMPTY;
            rel_d[fptr_q] = 1'b0;
            fptr_d        = fptr_q + name_width'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < num_names; i++) begin
                st_q[i]   <= S_EMPTY;
                data_q[i] <= '0;
            end
            rel_q  <= '0;
            fptr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            data_q <= data_d;
            rel_q  <= rel_d;
            fptr_q <= fptr_d;
            err_q  <= err_d;
        end
    end

    assign CMP_READY_1 = rdy1;
    assign CMP_READY_2 = rdy2;
    assign WE_1        = we1;
    assign WE_2        = we2;
    assign NAME_IN_1   = n1;
    assign NAME_IN_2   = n2;
    assign D_IN_1      = we1 ? data_q[n1] : '0;
    assign D_IN_2      = we2 ? data_q[n2] : '0;
    assign WFE         = wfe;
    assign W_F         = fptr_q;
    assign ERR         = err_q;
endmodule

// File: tb/tb_bypass_wb_sequencer.sv
// Bench for bypass_wb_sequencer: directed scenarios plus random traffic, all outputs
// compared every cycle against a per-name flag model of allocation, data, write and release.
module tb_bypass_wb_sequencer;
    localparam int NN = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ALLOC_FIRE = 1'b0;
    logic [2:0]  ALLOC_NAME = '0;
    logic        CMP_VALID_1 = 1'b0, CMP_VALID_2 = 1'b0;
    logic [2:0]  CMP_NAME_1 = '0, CMP_NAME_2 = '0;
    logic [31:0] CMP_DATA_1 = '0, CMP_DATA_2 = '0;
    logic        CMP_READY_1, CMP_READY_2;
    logic        REL_E_1 = 1'b0, REL_E_2 = 1'b0;
    logic [2:0]  REL_NAME_1 = '0, REL_NAME_2 = '0;
    logic        WE_1, WE_2;
    logic [2:0]  NAME_IN_1, NAME_IN_2;
    logic [31:0] D_IN_1, D_IN_2;
    logic        WFE;
    logic [2:0]  W_F;
    logic        F_READY = 1'b1;
    logic        ERR;

    bypass_wb_sequencer dut (
        .CLK(CLK), .RST(RST),
        .ALLOC_FIRE(ALLOC_FIRE), .ALLOC_NAME(ALLOC_NAME),
        .CMP_VALID_1(CMP_VALID_1), .CMP_NAME_1(CMP_NAME_1), .CMP_DATA_1(CMP_DATA_1), .CMP_READY_1(CMP_READY_1),
        .CMP_VALID_2(CMP_VALID_2), .CMP_NAME_2(CMP_NAME_2), .CMP_DATA_2(CMP_DATA_2), .CMP_READY_2(CMP_READY_2),
        .REL_E_1(REL_E_1), .REL_NAME_1(REL_NAME_1), .REL_E_2(REL_E_2), .REL_NAME_2(REL_NAME_2),
        .WE_1(WE_1), .NAME_IN_1(NAME_IN_1), .D_IN_1(D_IN_1),
        .WE_2(WE_2), .NAME_IN_2(NAME_IN_2), .D_IN_2(D_IN_2),
        .WFE(WFE), .W_F(W_F), .F_READY(F_READY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: one flag per fact about each name.
    bit          m_alloc [NN];
    bit          m_done  [NN];
    bit          m_wr    [NN];
    bit          m_rel   [NN];
    logic [31:0] m_dat   [NN];
    int          m_fp;
    bit          m_err;
    bit          mdl_live = 1'b0;
    int          ap = 0;

    bit e_rdy1, e_rdy2, e_we1, e_we2, e_wfe;
    int e_n1, e_n2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NN; i++) begin
            m_alloc[i] = 0; m_done[i] = 0; m_wr[i] = 0; m_rel[i] = 0; m_dat[i] = '0;
        end
        m_fp  = 0;
        m_err = 0;
        mdl_live = 1'b1;
    endtask

    task automatic check_outputs();
        int pl[$];
        e_rdy1 = m_alloc[CMP_NAME_1] && !m_done[CMP_NAME_1];
        e_rdy2 = m_alloc[CMP_NAME_2] && !m_done[CMP_NAME_2] && !(CMP_VALID_1 && CMP_NAME_1 == CMP_NAME_2);
        for (int k = 0; k < NN; k++) begin
            int n = (m_fp + k) % NN;
            if (m_alloc[n] && m_done[n] && !m_wr[n]) pl.push_back(n);
        end
        e_we1 = pl.size() > 0;
        e_we2 = pl.size() > 1;
        e_n1  = e_we1 ? pl[0] : 0;
        e_n2  = e_we2 ? pl[1] : 0;
        e_wfe = m_alloc[m_fp] && m_wr[m_fp] && m_rel[m_fp];
        chk("cmp_ready_1", CMP_READY_1, e_rdy1);
        chk("cmp_ready_2", CMP_READY_2, e_rdy2);
        chk("we_1", WE_1, e_we1);
        chk("we_2", WE_2, e_we2);
        if (e_we1) begin
            chk("name_in_1", NAME_IN_1, e_n1);
            chk("d_in_1", D_IN_1, m_dat[e_n1]);
        end
        if (e_we2) begin
            chk("name_in_2", NAME_IN_2, e_n2);
            chk("d_in_2", D_IN_2, m_dat[e_n2]);
        end
        chk("wfe", WFE, e_wfe);
        chk("w_f", W_F, m_fp);
        chk("err", ERR, m_err);
    endtask

    task automatic model_update();
        bit a_pre [NN];
        a_pre = m_alloc;
        if (e_we1) m_wr[e_n1] = 1;
        if (e_we2) m_wr[e_n2] = 1;
        if (CMP_VALID_1 && e_rdy1) begin m_done[CMP_NAME_1] = 1; m_dat[CMP_NAME_1] = CMP_DATA_1; end
        if (CMP_VALID_2 && e_rdy2) begin m_done[CMP_NAME_2] = 1; m_dat[CMP_NAME_2] = CMP_DATA_2; end
        if (REL_E_1) begin if (a_pre[REL_NAME_1]) m_rel[REL_NAME_1] = 1; else m_err = 1; end
        if (REL_E_2) begin if (a_pre[REL_NAME_2]) m_rel[REL_NAME_2] = 1; else m_err = 1; end
        if (ALLOC_FIRE) begin
            if (!a_pre[ALLOC_NAME]) begin
                m_alloc[ALLOC_NAME] = 1; m_done[ALLOC_NAME] = 0; m_wr[ALLOC_NAME] = 0; m_rel[ALLOC_NAME] = 0;
            end else m_err = 1;
        end
        if (e_wfe && F_READY) begin
            m_alloc[m_fp] = 0; m_done[m_fp] = 0; m_wr[m_fp] = 0; m_rel[m_fp] = 0;
            m_fp = (m_fp + 1) % NN;
        end
    endtask

    // Inputs are set at the falling edge; checks run just after, the model advances at the rising edge.
    task automatic step();
        #1;
        if (mdl_live && RST) check_outputs();
        @(posedge CLK);
        if (!RST) model_reset();
        else if (mdl_live) model_update();
        @(negedge CLK);
        ALLOC_FIRE = 0; CMP_VALID_1 = 0; CMP_VALID_2 = 0; REL_E_1 = 0; REL_E_2 = 0;
    endtask

    task automatic do_reset();
        RST = 0;
        step();
        step();
        chk("rst_cmp_ready_1", CMP_READY_1, 0);
        chk("rst_cmp_ready_2", CMP_READY_2, 0);
        chk("rst_we", {WE_1, WE_2}, 0);
        chk("rst_name_in", {NAME_IN_1, NAME_IN_2}, 0);
        chk("rst_d_in", {D_IN_1, D_IN_2}, 0);
        chk("rst_wfe", WFE, 0);
        chk("rst_w_f", W_F, 0);
        chk("rst_err", ERR, 0);
        RST = 1;
        F_READY = 1;
        ap = 0;
    endtask

    task automatic alloc(input int n);
        ALLOC_FIRE = 1; ALLOC_NAME = 3'(n);
        step();
    endtask

    function automatic int pick_cmp();
        int s = $urandom % NN;
        for (int k = 0; k < NN; k++) begin
            int n = (s + k) % NN;
            if (m_alloc[n] && !m_done[n]) return n;
        end
        return $urandom % NN;
    endfunction

    function automatic int pick_rel();
        int s = $urandom % NN;
        for (int k = 0; k < NN; k++) begin
            int n = (s + k) % NN;
            if (m_alloc[n] && !m_rel[n]) return n;
        end
        return -1;
    endfunction

    initial begin
        // Single completion: write appears exactly one cycle after acceptance.
        do_reset();
        alloc(0);
        CMP_VALID_1 = 1; CMP_NAME_1 = 0; CMP_DATA_1 = 32'hAA;
        step();
        chk("t1_we_1", WE_1, 1);
        chk("t1_name_in_1", NAME_IN_1, 0);
        chk("t1_d_in_1", D_IN_1, 32'hAA);

        // Two out-of-order completions in one cycle go out oldest first.
        do_reset();
        alloc(0); alloc(1); alloc(2);
        CMP_VALID_1 = 1; CMP_NAME_1 = 2; CMP_DATA_1 = 32'h2222;
        CMP_VALID_2 = 1; CMP_NAME_2 = 0; CMP_DATA_2 = 32'h0000_1000;
        step();
        chk("t2_port1_name", {WE_1, NAME_IN_1}, {1'b1, 3'd0});
        chk("t2_port2_name", {WE_2, NAME_IN_2}, {1'b1, 3'd2});
        chk("t2_port2_data", D_IN_2, 32'h2222);
        step();
        CMP_VALID_1 = 1; CMP_NAME_1 = 1; CMP_DATA_1 = 32'h1111;
        step();
        chk("t2_late_port1", {WE_1, NAME_IN_1, WE_2}, {1'b1, 3'd1, 1'b0});

        // Younger name written and released waits behind older name.
        do_reset();
        alloc(0); alloc(1);
        REL_E_1 = 1; REL_NAME_1 = 0; REL_E_2 = 1; REL_NAME_2 = 1;
        step();
        CMP_VALID_1 = 1; CMP_NAME_1 = 1; CMP_DATA_1 = 32'hB1;
        step();
        step();
        chk("t3_young_blocked", WFE, 0);
        CMP_VALID_2 = 1; CMP_NAME_2 = 0; CMP_DATA_2 = 32'hB0;
        step();
        step();
        chk("t3_free0", {WFE, W_F}, {1'b1, 3'd0});
        step();
        chk("t3_free1", {WFE, W_F}, {1'b1, 3'd1});
        step();
        chk("t3_done", WFE, 0);

        // Free back-pressure; completion and release in the same cycle.
        do_reset();
        alloc(0);
        CMP_VALID_1 = 1; CMP_NAME_1 = 0; CMP_DATA_1 = 32'hC0;
        REL_E_1 = 1; REL_NAME_1 = 0;
        step();
        F_READY = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold", {WFE, W_F}, {1'b1, 3'd0});
            step();
        end
        F_READY = 1;
        step();
        chk("t4_advance", {WFE, W_F}, {1'b0, 3'd1});

        // Fill all names, drain in order, pointer wraps back to 0.
        do_reset();
        for (int i = 0; i < NN; i++) alloc(i);
        for (int i = 0; i < NN; i += 2) begin
            CMP_VALID_1 = 1; CMP_NAME_1 = 3'(i);     CMP_DATA_1 = 32'(i * 16 + 1);
            CMP_VALID_2 = 1; CMP_NAME_2 = 3'(i + 1); CMP_DATA_2 = 32'(i * 16 + 2);
            REL_E_1 = 1; REL_NAME_1 = 3'(i); REL_E_2 = 1; REL_NAME_2 = 3'(i + 1);
            step();
        end
        for (int i = 0; i < 12; i++) step();
        chk("t5_wrapped", {WFE, W_F}, {1'b0, 3'd0});
        alloc(0);
        CMP_VALID_1 = 1; CMP_NAME_1 = 0; CMP_DATA_1 = 32'hD0; REL_E_1 = 1; REL_NAME_1 = 0;
        step();
        step();
        chk("t5_refree", {WFE, W_F}, {1'b1, 3'd0});
        step();
        chk("t5_err_clear", ERR, 0);

        // Random traffic; all stimulus legal so ERR must stay low.
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int r;
            if (($urandom % 3 == 0) && !m_alloc[ap]) begin
                ALLOC_FIRE = 1; ALLOC_NAME = 3'(ap); ap = (ap + 1) % NN;
            end
            CMP_VALID_1 = $urandom % 2; CMP_NAME_1 = 3'(pick_cmp()); CMP_DATA_1 = $urandom;
            CMP_VALID_2 = $urandom % 2; CMP_NAME_2 = 3'(pick_cmp()); CMP_DATA_2 = $urandom;
            r = pick_rel();
            if (r >= 0 && ($urandom % 3 == 0)) begin REL_E_1 = 1; REL_NAME_1 = 3'(r); end
            r = pick_rel();
            if (r >= 0 && ($urandom % 3 == 0)) begin REL_E_2 = 1; REL_NAME_2 = 3'(r); end
            F_READY = ($urandom % 4) != 0;
            step();
        end
        F_READY = 1;

        // Port collision and sticky error.
        do_reset();
        alloc(3);
        CMP_VALID_1 = 1; CMP_NAME_1 = 3; CMP_DATA_1 = 32'h33;
        CMP_VALID_2 = 1; CMP_NAME_2 = 3; CMP_DATA_2 = 32'h44;
        #1;
        chk("t6_collide", {CMP_READY_1, CMP_READY_2}, 2'b10);
        step();
        chk("t6_port1_data", {WE_1, D_IN_1}, {1'b1, 32'h33});
        REL_E_1 = 1; REL_NAME_1 = 5;
        step();
        chk("t6_err_set", ERR, 1);
        for (int i = 0; i < 3; i++) step();
        chk("t6_err_hold", ERR, 1);
        do_reset();
        chk("t6_err_cleared", ERR, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bypass_wb_sequencer.md
# bypass_wb_sequencer

Writeback/free sequencer that sits directly upstream of the bypassing register file's write and free-write ports. It accepts out-of-order result completions and release requests, keyed by the write names the register file hands out at allocation. It drives at most two register-file writes per cycle, oldest name first. It issues frees strictly in allocation order, which the register file's in-order free check requires.

## Interface
Parameters:
- data_width, 32, width of result data
- name_width, 3, width of a write name; numNames = 2**name_width entries tracked

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-low (state cleared on a rising edge while RST==0)
- ALLOC_FIRE  in  1  register-file write reservation granted this cycle (ALLOC_E && ALLOC_READY)
- ALLOC_NAME  in  name_width  name granted (register file NAME_OUT)
- CMP_VALID_1/2  in  1  completion request, port 1/2
- CMP_NAME_1/2  in  name_width  name completed
- CMP_DATA_1/2  in  data_width  result data
- CMP_READY_1/2  out  1  completion accepted when VALID&&READY
- REL_E_1/2  in  1  release request (pipeline done with name)
- REL_NAME_1/2  in  name_width  name released
- WE_1/2  out  1  register-file write enable
- NAME_IN_1/2  out  name_width  register-file write name
- D_IN_1/2  out  data_width  register-file write data
- WFE  out  1  register-file free enable
- W_F  out  name_width  name to free
- F_READY  in  1  register-file free ready
- ERR  out  1  sticky protocol-violation flag

## Operation
- Per-name state: EMPTY, ALLOC, PEND (data buffered), WRIT (written to RF). There is also a per-name rel bit and a per-name data register.
- EMPTY->ALLOC on ALLOC_FIRE for ALLOC_NAME. Alloc of a non-EMPTY name: ignored, ERR set. This includes a name being freed in the same cycle.
- CMP_READY_k = state[CMP_NAME_k]==ALLOC. If both ports target the same name, port 1 wins and CMP_READY_2=0. An accepted completion sets state to PEND and stores the data.
- Write issue is combinational from registered state:
  - Scan names from fptr upward, with wrap-around.
  - The first PEND name drives port 1; the second PEND name drives port 2.
  - Issued names go to WRIT at the clock edge.
  - No PEND names: WE_1=WE_2=0. Exactly one PEND name: it uses port 1.
- Release: REL_E_k sets rel[REL_NAME_k] if the state is non-EMPTY; otherwise ERR is set. Release is legal in ALLOC/PEND/WRIT and is always accepted; there is no ready signal.
- Free: fptr (name_width, reset 0) is the oldest allocated name.
  - WFE = state[fptr]==WRIT && rel[fptr].
  - W_F = fptr at all times.
  - On WFE && F_READY: state[fptr]->EMPTY, rel cleared, fptr+1 with natural wrap modulo numNames.
  - A younger name that is WRIT and released waits behind an older unfinished name.
- Simultaneous events:
  - Completion accepted and the same name released in one cycle: both take effect.
  - Release on the same cycle as the name becomes WRIT: the free is eligible next cycle.
- ERR, once set, holds until reset. It never blocks operation.

## Timing
- Reset values: all states EMPTY, rel=0, fptr=0, ERR=0. Hence CMP_READY_1/2=0, WE_1/2=0, WFE=0, W_F=0, NAME_IN_1/2=0, D_IN_1/2=0.
- Alloc at edge t: CMP_READY may assert in cycle t+1.
- Completion accepted in cycle t: WE asserted for it in cycle t+1 at earliest (one-cycle buffer). If a third or later PEND name is present, it waits.
- Name becomes WRIT at edge t+2. If already released, WFE asserts in cycle t+2.
- Throughput: 2 completions, 2 writes, 1 free per cycle.
- Reset mid-operation: all buffered data and rel bits are discarded. The register file is reset together with this block.

## Test plan
- Reset with RST=0 for 2 cycles: all outputs 0. Alloc name 0 then CMP_NAME_1=0, data 0xAA -> WE_1=1, NAME_IN_1=0, D_IN_1=0xAA exactly one cycle after acceptance.
- Alloc 0,1,2. Complete 2 and 0 in the same cycle -> next cycle port 1 writes name 0, port 2 writes name 2. Complete 1 later -> written on port 1.
- Alloc 0,1. Release both. Complete 1 first, then 0 three cycles later -> WFE with W_F=1 never precedes the free of 0. Sequence is W_F=0 then W_F=1 on consecutive cycles with F_READY=1.
- Hold F_READY=0 with name 0 WRIT and released -> WFE stays 1 and W_F=0 until F_READY=1. fptr then advances.
- Fill all 8 names and free them in order, then alloc name 0 again -> fptr wraps 7->0 and name 0 cycles normally. ERR stays 0.
- Both completion ports target name 3 -> CMP_READY_1=1, CMP_READY_2=0. Release an EMPTY name 5 -> ERR=1 and held until reset.
